// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: word size, state
// encoding and the default bubble instruction.
package fetch_stage_pkg;

  localparam int ISIZE = 16;

  localparam logic [ISIZE-1:0] NOP_INST_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch address register: reset to RESET_PC, load on redirect, otherwise
// advance by one (wrapping) when inc_en is set.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [ISIZE-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ISIZE-1:0] load_val,
  input  logic             inc_en,
  output logic [ISIZE-1:0] pc
);

  logic [ISIZE-1:0] pc_d;
  logic [ISIZE-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a 1-cycle-latency instruction memory and
// presents instructions to decode, holding them across decode stalls.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ISIZE-1:0] RESET_PC = 16'h0000,
  parameter logic [ISIZE-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [ISIZE-1:0] redirect_pc,
  output logic [ISIZE-1:0] imem_addr,
  output logic             imem_rd,
  input  logic [ISIZE-1:0] imem_data,
  output logic [ISIZE-1:0] inst_out,
  output logic             inst_valid,
  output logic [ISIZE-1:0] pc_out,
  output logic [ISIZE-1:0] npc_out
);

  fetch_state_e     state_d, state_q;
  logic [ISIZE-1:0] hold_inst_d, hold_inst_q;
  logic [ISIZE-1:0] hold_pc_d, hold_pc_q;
  logic [ISIZE-1:0] disp_pc_d, disp_pc_q;
  logic [ISIZE-1:0] fetch_pc;
  logic             pc_inc;
  logic             pc_load;
  logic             valid_c;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (redirect_pc),
    .inc_en   (pc_inc),
    .pc       (fetch_pc)
  );

  always_comb begin
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    disp_pc_d   = disp_pc_q;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    valid_c     = 1'b0;
    case (state_q)
      ST_BUBBLE: begin
        pc_inc  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        valid_c = 1'b1;
        if (stall) begin
          // Memory data is only good for one cycle, so capture it for replay.
          hold_inst_d = imem_data;
          hold_pc_d   = disp_pc_q;
          state_d     = ST_HOLD;
        end else begin
          pc_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        valid_c = 1'b1;
        if (!stall) begin
          pc_inc  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BUBBLE;
    endcase
    // A taken branch squashes whatever is presented, including held work.
    if (redirect) begin
      valid_c     = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b1;
      state_d     = ST_BUBBLE;
      hold_inst_d = NOP_INST;
      hold_pc_d   = '0;
    end
    if (pc_inc || pc_load) begin
      disp_pc_d = fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BUBBLE;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= '0;
      disp_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      disp_pc_q   <= disp_pc_d;
    end
  end

  always_comb begin
    imem_addr  = fetch_pc;
    imem_rd    = !rst;
    inst_valid = !rst && valid_c;
    inst_out   = NOP_INST;
    pc_out     = '0;
    if (inst_valid) begin
      inst_out = (state_q == ST_HOLD) ? hold_inst_q : imem_data;
    end
    if (!rst) begin
      pc_out = (state_q == ST_HOLD) ? hold_pc_q : disp_pc_q;
    end
    npc_out = pc_out + 16'd1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle expectations are queued as each
// step is driven and compared when the outputs settle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data, inst_out, pc_out, npc_out;
  logic        imem_rd, inst_valid;
  logic [15:0] imem_addr2, imem_data2, inst_out2, pc_out2, npc_out2;
  logic        imem_rd2, inst_valid2;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst_c;
    logic        v;
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] addr;
    logic        chk2;
    logic [15:0] pc2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .inst_out(inst_out), .inst_valid(inst_valid),
    .pc_out(pc_out), .npc_out(npc_out)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .NOP_INST(16'h0000)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(16'h0000), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
    .imem_data(imem_data2), .inst_out(inst_out2), .inst_valid(inst_valid2),
    .pc_out(pc_out2), .npc_out(npc_out2)
  );

  // memory[n] = 16'h1000 + n, one cycle read latency
  always @(posedge clk) begin
    imem_data  <= 16'h1000 + imem_addr;
    imem_data2 <= 16'h1000 + imem_addr2;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle. When ev=1 the presented instruction must be memory[epc];
  // pc/npc are only checked for valid cycles and reset cycles.
  task automatic cyc(input logic r_rst, input logic s, input logic rd,
                     input logic [15:0] rpc, input logic ev,
                     input logic [15:0] epc, input logic [15:0] eaddr,
                     input logic c2, input logic [15:0] e2pc);
    exp_t e, o;
    rst = r_rst; stall = s; redirect = rd; redirect_pc = rpc;
    e.rst_c = r_rst; e.v = ev; e.inst = ev ? 16'h1000 + epc : 16'h0000;
    e.pc = epc; e.addr = eaddr; e.chk2 = c2; e.pc2 = e2pc;
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    chk("valid", {15'd0, inst_valid}, {15'd0, o.v});
    chk("inst", inst_out, o.inst);
    chk("imem_addr", imem_addr, o.addr);
    chk("imem_rd", {15'd0, imem_rd}, {15'd0, !o.rst_c});
    if (o.v || o.rst_c) begin
      chk("pc_out", pc_out, o.pc);
      chk("npc_out", npc_out, o.pc + 16'd1);
    end
    if (o.chk2) begin
      chk("wrap_valid", {15'd0, inst_valid2}, 16'd1);
      chk("wrap_inst", inst_out2, 16'h1000 + o.pc2);
      chk("wrap_pc", pc_out2, o.pc2);
      chk("wrap_npc", npc_out2, o.pc2 + 16'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic post_reset_run(input logic with_wrap);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0000, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h0, 16'h0001, with_wrap, 16'hFFFE);
    cyc(0, 0, 0, 16'h0, 1, 16'h1, 16'h0002, with_wrap, 16'hFFFF);
    cyc(0, 0, 0, 16'h0, 1, 16'h2, 16'h0003, with_wrap, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    @(posedge clk);
    #1;
    // Reset held: outputs forced idle
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0000, 0, 16'h0);
    cyc(1, 1, 1, 16'h9, 0, 16'h0, 16'h0000, 0, 16'h0);
    post_reset_run(1'b1);
    cyc(0, 0, 0, 16'h0, 1, 16'h3, 16'h0004, 0, 16'h0);
    // Stall three cycles while 0x1004 is presented
    cyc(0, 1, 0, 16'h0, 1, 16'h4, 16'h0005, 0, 16'h0);
    cyc(0, 1, 0, 16'h0, 1, 16'h4, 16'h0005, 0, 16'h0);
    cyc(0, 1, 0, 16'h0, 1, 16'h4, 16'h0005, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h4, 16'h0005, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h5, 16'h0006, 0, 16'h0);
    // Redirect to 0x40 while 0x1006 is presented
    cyc(0, 0, 1, 16'h0040, 0, 16'h0, 16'h0007, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0040, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h0040, 16'h0041, 0, 16'h0);
    // Redirect together with stall while holding: redirect wins
    cyc(0, 1, 0, 16'h0, 1, 16'h0041, 16'h0042, 0, 16'h0);
    cyc(0, 1, 1, 16'h0080, 0, 16'h0, 16'h0042, 0, 16'h0);
    cyc(0, 1, 0, 16'h0, 0, 16'h0, 16'h0080, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h0080, 16'h0081, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'h0081, 16'h0082, 0, 16'h0);
    // Reset arrives in the middle of a two-cycle stall
    cyc(0, 1, 0, 16'h0, 1, 16'h0082, 16'h0083, 0, 16'h0);
    cyc(1, 1, 0, 16'h0, 0, 16'h0, 16'h0083, 0, 16'h0);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0000, 0, 16'h0);
    post_reset_run(1'b0);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 16'h0000, is the value driven on inst_out when inst_valid=0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  decode cannot accept the presented instruction this cycle.
REQ-006 redirect  in  1  taken branch resolved in EXE this cycle.
REQ-007 redirect_pc  in  16  branch target address, valid when redirect=1.
REQ-008 imem_addr  out  16  fetch address to instruction memory; equals fetch_pc register.
REQ-009 imem_rd  out  1  memory read enable; 0 during rst, else 1.
REQ-010 imem_data  in  16  instruction memory data; returns word for imem_addr of previous cycle (1-cycle latency).
REQ-011 inst_out  out  16  instruction presented to decode.
REQ-012 inst_valid  out  1  inst_out is a real, on-path instruction.
REQ-013 pc_out  out  16  address of presented instruction.
REQ-014 npc_out  out  16  pc_out+1, mod 2^16 (feeds branch adder).

Function
REQ-015 States: BUBBLE (output invalid), RUN (output = imem_data), HOLD (output = hold register).
REQ-016 BUBBLE: inst_valid=0, inst_out=NOP_INST; stall ignored; fetch_pc<=fetch_pc+1; next RUN.
REQ-017 RUN, stall=0: inst_out=imem_data, inst_valid=1; fetch_pc<=fetch_pc+1; stay RUN.
REQ-018 RUN, stall=1: inst_out=imem_data, inst_valid=1; hold_inst<=imem_data, hold_pc<=pc_out; fetch_pc unchanged; next HOLD.
REQ-019 HOLD, stall=1: inst_out=hold_inst, pc_out=hold_pc, inst_valid=1; fetch_pc unchanged; stay HOLD.
REQ-020 HOLD, stall=0: present hold_inst (consumed this cycle); fetch_pc<=fetch_pc+1; next RUN.
REQ-021 Presented-PC register disp_pc<=imem_addr whenever fetch_pc advances or is redirected; pc_out=disp_pc in BUBBLE/RUN, hold_pc in HOLD.
REQ-022 Latency: instruction at address p appears on inst_out the cycle after imem_addr=p, absent stall/redirect.
REQ-023 redirect=1 in any state: inst_valid forced 0 this cycle; fetch_pc<=redirect_pc; hold contents discarded; next BUBBLE.
REQ-024 Priority: rst > redirect > stall.
REQ-025 First valid instruction after redirect appears exactly 2 cycles after the redirect cycle.
REQ-026 fetch_pc increment wraps 16'hFFFF -> 16'h0000; npc_out likewise wraps.
REQ-027 Stall of any length loses and duplicates no instruction; each valid instruction is consumed exactly once (valid=1, stall=0).

Reset
REQ-028 On rst=1 at a clock edge: fetch_pc<=RESET_PC, state<=BUBBLE, hold_inst<=NOP_INST, hold_pc<=0, disp_pc<=0.
REQ-029 While rst=1: inst_valid=0, inst_out=NOP_INST, pc_out=0, npc_out=1, imem_rd=0.
REQ-030 rst asserted mid-stall or mid-redirect abandons all in-flight state; first valid output (RESET_PC) appears 2 cycles after rst deasserts.

Structure
REQ-031 Shared package holds ISIZE=16, the fetch state encoding (BUBBLE/RUN/HOLD), and NOP_INST default.
REQ-032 One sub-module fetch_pc_reg: 16-bit PC register with load (redirect/reset) and increment-enable inputs; all other logic lives in fetch_stage.

Verification
REQ-033 Reset, RESET_PC=0, memory[n]=16'h1000+n, no stall -> cycles 2,3,4 after rst release show inst 1000/1001/1002, pc_out 0/1/2, npc_out 1/2/3.
REQ-034 Stall 3 cycles while 16'h1004 presented -> 1004 held 4 cycles, imem_addr frozen at 5; 1005 presented the cycle after stall drops; no skips or duplicates.
REQ-035 redirect=1, redirect_pc=16'h0040 while 1006 presented -> valid=0 that cycle and the next; following cycle inst=memory[0x40], pc_out=0x40, npc_out=0x41.
REQ-036 redirect and stall asserted together in HOLD -> redirect wins; hold discarded; memory[target] valid 2 cycles later.
REQ-037 RESET_PC=16'hFFFE, free run -> pc_out FFFE, FFFF, 0000; npc_out FFFF, 0000, 0001.
REQ-038 rst asserted during 2-cycle stall -> outputs invalid/NOP during rst; post-reset sequence identical to REQ-033.
